// File: rtl/fetch_unit_if.sv
// Bus bundle for the instruction-fetch stage: redirect input, the
// instruction-memory request/grant/response channel and the IF/ID handshake.
interface fetch_unit_if;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRValid;
  logic [31:0] ImemRData;
  logic        IFIDValid;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPC;
  logic [31:0] IFIDPCPlus4;
  logic        IDReady;

  // Fetch-unit side
  modport master (
    input  Redirect, RedirectPC, ImemGnt, ImemRValid, ImemRData, IDReady,
    output ImemReq, ImemAddr, IFIDValid, IFIDInstr, IFIDPC, IFIDPCPlus4
  );

  // Environment side (memory, decode and branch resolution)
  modport slave (
    output Redirect, RedirectPC, ImemGnt, ImemRValid, ImemRData, IDReady,
    input  ImemReq, ImemAddr, IFIDValid, IFIDInstr, IFIDPC, IFIDPCPlus4
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, issues in-order requests to
// instruction memory, tags each grant with its address, buffers returned
// instructions with their PCs and hands them to decode. A redirect flushes
// the buffer and marks every outstanding request as stale so its response
// is thrown away when it arrives.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_unit_if.master bus
);

  localparam int              AW    = $clog2(DEPTH);
  localparam int              CW    = AW + 1;
  localparam logic [CW:0]     LIMIT = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0]   PTR1  = AW'(1);

  logic [31:0]   r_fpc;
  logic [CW-1:0] r_infl;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_occ;
  logic [AW-1:0] r_tag_wp;
  logic [AW-1:0] r_tag_rp;
  logic [AW-1:0] r_ib_wp;
  logic [AW-1:0] r_ib_rp;
  logic [31:0]   r_tag      [DEPTH];
  logic [31:0]   r_ib_instr [DEPTH];
  logic [31:0]   r_ib_pc    [DEPTH];

  logic [CW:0]   w_used;
  logic          w_req;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_keep;
  logic          w_valid;
  logic          w_pop;
  logic          w_drop_any;

  // Request throttle counts both outstanding fetches and buffered ones so a
  // granted request always has a buffer slot waiting for its response.
  assign w_used     = {1'b0, r_infl} + {1'b0, r_occ};
  assign w_req      = ~bus.Redirect & (w_used < LIMIT);
  assign w_gnt      = w_req & bus.ImemGnt;
  // A response with nothing outstanding is a protocol error; ignore it.
  assign w_rsp      = bus.ImemRValid & (r_infl != '0);
  assign w_drop_any = (r_drop != '0);
  assign w_keep     = w_rsp & ~w_drop_any & ~bus.Redirect;
  assign w_valid    = (r_occ != '0);
  assign w_pop      = w_valid & bus.IDReady & ~bus.Redirect;

  assign bus.ImemReq     = w_req;
  assign bus.ImemAddr    = r_fpc;
  assign bus.IFIDValid   = w_valid;
  assign bus.IFIDInstr   = w_valid ? r_ib_instr[r_ib_rp] : '0;
  assign bus.IFIDPC      = w_valid ? r_ib_pc[r_ib_rp] : '0;
  assign bus.IFIDPCPlus4 = w_valid ? (r_ib_pc[r_ib_rp] + 32'd4) : '0;

  // Control state: fetch PC, counters and FIFO pointers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fpc    <= RESET_PC;
      r_infl   <= '0;
      r_drop   <= '0;
      r_occ    <= '0;
      r_tag_wp <= '0;
      r_tag_rp <= '0;
      r_ib_wp  <= '0;
      r_ib_rp  <= '0;
    end else begin
      r_infl <= r_infl + CW'(w_gnt) - CW'(w_rsp);
      if (w_gnt) r_tag_wp <= r_tag_wp + PTR1;
      if (w_rsp) r_tag_rp <= r_tag_rp + PTR1;
      if (bus.Redirect) begin
        // Everything still outstanding after this cycle is stale; this
        // already includes any earlier stale requests.
        r_fpc   <= bus.RedirectPC;
        r_drop  <= r_infl - CW'(w_rsp);
        r_occ   <= '0;
        r_ib_wp <= '0;
        r_ib_rp <= '0;
      end else begin
        if (w_gnt) r_fpc <= r_fpc + 32'd4;
        if (w_rsp && w_drop_any) r_drop <= r_drop - CW'(1);
        r_occ <= r_occ + CW'(w_keep) - CW'(w_pop);
        if (w_keep) r_ib_wp <= r_ib_wp + PTR1;
        if (w_pop)  r_ib_rp <= r_ib_rp + PTR1;
      end
    end
  end

  // Storage: address tags on grant, {instr, pc} on an accepted response.
  always_ff @(posedge Clk) begin
    if (w_gnt) r_tag[r_tag_wp] <= r_fpc;
    if (w_keep) begin
      r_ib_instr[r_ib_wp] <= bus.ImemRData;
      r_ib_pc[r_ib_wp]    <= r_tag[r_tag_rp];
    end
  end

  a_rsp_outstanding: assert property (
    @(posedge Clk) disable iff (!Reset) bus.ImemRValid |-> (r_infl != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the fetch stage.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic Clk;
  logic Reset;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] a; bit stale; }           out_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } buf_t;

  // Model state
  out_t        m_out[$];
  buf_t        m_buf[$];
  logic [31:0] m_fpc;

  // Memory model state
  logic [31:0] mq_addr[$];
  int          mq_cyc[$];
  int          lat;
  int          rsp_pct;
  logic [31:0] dmask;

  int          cyc;
  int          n_checks;
  int          n_errors;
  int          n_gnt;
  logic [31:0] cons_q[$];
  logic        s_valid;
  logic        s_req;
  logic [31:0] s_addr;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    #3;
    Reset          = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = '0;
    bus.ImemGnt    = 1'b0;
    bus.ImemRValid = 1'b0;
    bus.ImemRData  = '0;
    bus.IDReady    = 1'b0;
    #1;
    chk("rst_valid", {31'b0, bus.IFIDValid}, 32'd0);
    chk("rst_req",   {31'b0, bus.ImemReq},   32'd1);
    chk("rst_addr",  bus.ImemAddr,           32'h0000_0000);
    chk("rst_instr", bus.IFIDInstr,          32'd0);
    chk("rst_pc",    bus.IFIDPC,             32'd0);
    chk("rst_pc4",   bus.IFIDPCPlus4,        32'd0);
    m_out.delete();
    m_buf.delete();
    m_fpc = RESET_PC;
    mq_addr.delete();
    mq_cyc.delete();
    @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model and the memory by what the coming edge will do.
  task automatic step(input logic redir, input logic [31:0] rpc,
                      input logic rdy, input logic gnt);
    logic        rv;
    logic [31:0] rd;
    logic        exp_req;
    logic        exp_valid;
    logic        g_dut;
    out_t        e;
    @(negedge Clk);
    rv = 1'b0;
    rd = $urandom();
    if (mq_addr.size() > 0 && cyc >= mq_cyc[0] + lat &&
        $urandom_range(0, 99) < rsp_pct) begin
      rv = 1'b1;
      rd = mq_addr[0] ^ dmask;
    end
    bus.Redirect   = redir;
    bus.RedirectPC = rpc;
    bus.IDReady    = rdy;
    bus.ImemGnt    = gnt;
    bus.ImemRValid = rv;
    bus.ImemRData  = rd;
    #1;
    exp_req   = !redir && ((m_out.size() + m_buf.size()) < DEPTH);
    exp_valid = (m_buf.size() > 0);
    chk("req",   {31'b0, bus.ImemReq},   {31'b0, exp_req});
    chk("addr",  bus.ImemAddr,           m_fpc);
    chk("valid", {31'b0, bus.IFIDValid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("instr", bus.IFIDInstr,   m_buf[0].instr);
      chk("pc",    bus.IFIDPC,      m_buf[0].pc);
      chk("pc4",   bus.IFIDPCPlus4, m_buf[0].pc + 32'd4);
    end
    s_valid = bus.IFIDValid;
    s_req   = bus.ImemReq;
    s_addr  = bus.ImemAddr;
    g_dut   = bus.ImemReq & gnt;
    if (g_dut) n_gnt++;

    if (exp_valid && rdy) begin
      cons_q.push_back(m_buf[0].pc);
      void'(m_buf.pop_front());
    end
    if (rv && m_out.size() > 0) begin
      e = m_out.pop_front();
      if (!e.stale && !redir) m_buf.push_back('{rd, e.a});
    end
    if (redir) begin
      m_buf.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_fpc = rpc;
    end else if (exp_req && gnt) begin
      m_out.push_back('{m_fpc, 1'b0});
      m_fpc = m_fpc + 32'd4;
    end

    if (rv) begin
      void'(mq_addr.pop_front());
      void'(mq_cyc.pop_front());
    end
    if (g_dut) begin
      mq_addr.push_back(bus.ImemAddr);
      mq_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic rdy, input logic gnt);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, rdy, gnt);
  endtask

  function automatic logic [31:0] cons_at(input int i);
    if (i < cons_q.size()) return cons_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rr;
    logic [31:0] rpc;
    n_checks = 0; n_errors = 0; cyc = 0; n_gnt = 0;
    lat = 1; rsp_pct = 100; dmask = '0;
    Reset = 1'b0;
    bus.Redirect = 1'b0; bus.RedirectPC = '0; bus.ImemGnt = 1'b0;
    bus.ImemRValid = 1'b0; bus.ImemRData = '0; bus.IDReady = 1'b0;

    // Streaming at full rate, data = address
    do_reset();
    cons_q.delete();
    run(12, 1'b1, 1'b1);
    chk("stream_n",   cons_q.size(), 32'd10);
    chk("stream_pc0", cons_at(0), 32'h0);
    chk("stream_pc1", cons_at(1), 32'h4);
    chk("stream_pc2", cons_at(2), 32'h8);
    chk("stream_pc3", cons_at(3), 32'hC);

    // Decode stalled: exactly DEPTH grants, then drain in order
    do_reset();
    cons_q.delete();
    n_gnt = 0;
    run(10, 1'b0, 1'b1);
    chk("stall_gnts", n_gnt, 32'd4);
    chk("stall_req",  {31'b0, s_req}, 32'd0);
    run(8, 1'b1, 1'b1);
    chk("drain_pc0", cons_at(0), 32'h0);
    chk("drain_pc1", cons_at(1), 32'h4);
    chk("drain_pc2", cons_at(2), 32'h8);
    chk("drain_pc3", cons_at(3), 32'hC);

    // Redirect with two requests in flight on 3-cycle memory
    do_reset();
    lat = 3;
    run(2, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    cons_q.delete();
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("redir_addr",  s_addr, 32'h100);
    chk("redir_valid", {31'b0, s_valid}, 32'd0);
    run(12, 1'b1, 1'b1);
    chk("redir_pc0", cons_at(0), 32'h100);
    chk("redir_pc1", cons_at(1), 32'h104);

    // Redirect coinciding with a response and a consume
    do_reset();
    lat = 1;
    run(5, 1'b1, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    cons_q.delete();
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("coll_addr",  s_addr, 32'h200);
    chk("coll_valid", {31'b0, s_valid}, 32'd0);
    run(6, 1'b1, 1'b1);
    chk("coll_pc0", cons_at(0), 32'h200);

    // Address wrap
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    cons_q.delete();
    run(8, 1'b1, 1'b1);
    chk("wrap_pc0", cons_at(0), 32'hFFFF_FFF8);
    chk("wrap_pc1", cons_at(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", cons_at(2), 32'h0000_0000);

    // Reset in the middle of a stream with two in flight
    do_reset();
    lat = 3;
    run(2, 1'b1, 1'b1);
    do_reset();
    lat = 1;
    cons_q.delete();
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("rst2_addr", s_addr, 32'h0);
    run(6, 1'b1, 1'b1);
    chk("rst2_pc0", cons_at(0), 32'h0);
    chk("rst2_pc1", cons_at(1), 32'h4);

    // Randomized traffic
    dmask = 32'h1357_9BDF;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        lat     = $urandom_range(1, 4);
        rsp_pct = ($urandom_range(0, 1) == 0) ? 100 : 70;
      end
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      rr  = ($urandom_range(0, 99) < 5);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      step(rr, rpc, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 80));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
